// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: accumulates signed booth products into saturating dot-product results on a valid/ready port
module booth_mac_accumulator #(
  parameter int N = 8,
  parameter int ACC_W = 24,
  parameter bit SAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [15:0]      out_terms
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc, prod_x, acc_upd, sat_val;
  logic [ACC_W:0] sum;
  logic [15:0] terms, terms_upd;
  logic ovf, ovf_upd, of, beat, restart;
  assign in_ready = !rst && (!out_valid || out_ready);
  assign beat = in_valid && in_ready;
  assign restart = state == IDLE || in_first;
  assign prod_x = ACC_W'($signed(in_prod));
  assign sum = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};
  assign of = sum[ACC_W] != sum[ACC_W-1];
  assign sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign acc_upd = restart ? prod_x : (SAT && of) ? sat_val : sum[ACC_W-1:0];
  assign ovf_upd = restart ? 1'b0 : ovf || of;
  assign terms_upd = restart ? 16'd1 : terms + 16'(terms != 16'hFFFF);
  always_comb begin
    state_nxt = state;
    if (beat) state_nxt = in_last ? IDLE : ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      terms <= '0;
      out_valid <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
      out_terms <= '0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        acc <= in_last ? '0 : acc_upd;
        ovf <= in_last ? 1'b0 : ovf_upd;
        terms <= in_last ? '0 : terms_upd;
      end
      if (beat && in_last) begin
        out_valid <= 1'b1;
        out_acc <= acc_upd;
        out_ovf <= ovf_upd;
        out_terms <= terms_upd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
